// File: rtl/bsg_manycore_io_link_arbiter.sv
// Round-robin arbiter folding the IO-row column request streams onto one host
// request port, with a single registered output slot and credit-based flow control.
module bsg_manycore_io_link_arbiter #(
  parameter int num_cols_p      = 4,
  parameter int packet_width_p  = 64,
  parameter int max_credits_p   = 8,
  localparam int credit_width_lp = $clog2(max_credits_p + 1),
  localparam int col_id_width_lp = $clog2(num_cols_p)
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [num_cols_p-1:0]                req_v_i,
  input  logic [num_cols_p*packet_width_p-1:0] req_data_i,
  output logic [num_cols_p-1:0]                req_ready_o,
  output logic                                 host_v_o,
  output logic [packet_width_p-1:0]            host_data_o,
  output logic [col_id_width_lp-1:0]           host_col_o,
  input  logic                                 host_ready_i,
  input  logic                                 credit_return_i,
  output logic [credit_width_lp-1:0]           credits_o,
  output logic                                 credit_overflow_o
);

  localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_credits_p);
  localparam logic [col_id_width_lp-1:0] last_col_lp    = col_id_width_lp'(num_cols_p - 1);

  logic                          host_v_q, host_v_d;
  logic [packet_width_p-1:0]     host_data_q, host_data_d;
  logic [col_id_width_lp-1:0]    host_col_q, host_col_d;
  logic [col_id_width_lp-1:0]    rr_ptr_q, rr_ptr_d;
  logic [credit_width_lp-1:0]    credits_q, credits_d;
  logic                          overflow_q, overflow_d;
  logic [col_id_width_lp-1:0]    winner_s, idx_s;
  logic                          found_s, can_accept_s, grant_s;
  logic [num_cols_p-1:0]         ready_s;

  // Rotating priority search starting just after the last winner.
  always_comb begin
    winner_s = '0;
    found_s  = 1'b0;
    idx_s    = '0;
    for (int i = 1; i <= num_cols_p; i++) begin
      idx_s = col_id_width_lp'((int'(rr_ptr_q) + i) % num_cols_p);
      if (!found_s && req_v_i[idx_s]) begin
        found_s  = 1'b1;
        winner_s = idx_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Grant qualification; the slot refills in the same cycle the host drains it.
  always_comb begin
    can_accept_s = ~host_v_q | host_ready_i;
    grant_s      = can_accept_s & (credits_q != '0) & found_s & ~reset_i;
    ready_s      = '0;
    if (grant_s) begin
      ready_s[winner_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  // Next-state for the output slot, round-robin pointer and credit counter.
  always_comb begin
    host_v_d    = host_v_q;
    host_data_d = host_data_q;
    host_col_d  = host_col_q;
    rr_ptr_d    = rr_ptr_q;
    credits_d   = credits_q;
    overflow_d  = overflow_q;

    if (grant_s) begin
      host_v_d    = 1'b1;
      host_data_d = req_data_i[winner_s*packet_width_p +: packet_width_p];
      host_col_d  = winner_s;
      rr_ptr_d    = winner_s;
    end else if (host_ready_i) begin
      host_v_d = 1'b0;
    end else begin
      host_v_d = host_v_q;
    end

    // Credits are reserved at grant time; a return on a full counter is an error.
    if (grant_s && !credit_return_i) begin
      credits_d = credits_q - credit_width_lp'(1);
    end else if (!grant_s && credit_return_i) begin
      if (credits_q == max_credits_lp) begin
        overflow_d = 1'b1;
      end else begin
        credits_d = credits_q + credit_width_lp'(1);
      end
    end else begin
      credits_d = credits_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      host_v_q    <= 1'b0;
      host_data_q <= '0;
      host_col_q  <= '0;
      rr_ptr_q    <= last_col_lp;
      credits_q   <= max_credits_lp;
      overflow_q  <= 1'b0;
    end else begin
      host_v_q    <= host_v_d;
      host_data_q <= host_data_d;
      host_col_q  <= host_col_d;
      rr_ptr_q    <= rr_ptr_d;
      credits_q   <= credits_d;
      overflow_q  <= overflow_d;
    end
  end

  assign req_ready_o       = ready_s;
  assign host_v_o          = host_v_q;
  assign host_data_o       = host_data_q;
  assign host_col_o        = host_col_q;
  assign credits_o         = credits_q;
  assign credit_overflow_o = overflow_q;

  bsg_manycore_io_link_arbiter_chk #(.num_cols_p(num_cols_p)) chk (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .req_v_i        (req_v_i),
    .req_ready_i    (ready_s),
    .credit_return_i(credit_return_i)
  );

endmodule

// Interface-protocol checks for the arbiter; simulation only.
module bsg_manycore_io_link_arbiter_chk #(
  parameter int num_cols_p = 4
) (
  input logic                  clk_i,
  input logic                  reset_i,
  input logic [num_cols_p-1:0] req_v_i,
  input logic [num_cols_p-1:0] req_ready_i,
  input logic                  credit_return_i
);

  a_ready_onehot0: assert property (@(posedge clk_i) disable iff (reset_i)
    $onehot0(req_ready_i)) else $error("req_ready_o not one-hot0");

  a_return_known: assert property (@(posedge clk_i) disable iff (reset_i)
    !$isunknown(credit_return_i)) else $error("credit_return_i unknown");

  for (genvar c = 0; c < num_cols_p; c++) begin : g_hold
    a_valid_hold: assert property (@(posedge clk_i) disable iff (reset_i)
      (req_v_i[c] && !req_ready_i[c]) |=> req_v_i[c])
      else $warning("req_v_i[%0d] dropped while unserved", c);
  end

endmodule
